// File: rtl/branch_sequencer.sv
// branch_sequencer: PC and condition-flag sequencer for the KGP-RISC core.
// It holds the carry/zero/sign flags written by the ALU and presents them,
// with the issuing branch code, to the combinational branch checker. It acts
// on the returned jump decision, squashes the wrong-path slot after a taken
// branch, counts taken branches and supports halt.
module branch_sequencer #(
   parameter int              PC_W     = 32,
   parameter int              OFF_W    = 26,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [2:0]        branch_code,
   input  logic [OFF_W-1:0]  offset,
   input  logic [PC_W-1:0]   reg_target,
   input  logic              flag_we,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_sign,
   input  logic              halt_req,
   input  logic              jump,
   output logic [2:0]        branch,
   output logic              carry,
   output logic              zero,
   output logic              sign,
   output logic [PC_W-1:0]   pc,
   output logic              pc_valid,
   output logic              flush,
   output logic              halted,
   output logic [15:0]       taken_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

   localparam logic [2:0] CODE_NONE = 3'b000;
   localparam logic [2:0] CODE_BR   = 3'b010;

   state_t            state_reg;
   logic [PC_W-1:0]   pc_reg;
   logic              carry_reg;
   logic              zero_reg;
   logic              sign_reg;
   logic              pc_valid_reg;
   logic              flush_reg;
   logic              halted_reg;
   logic [15:0]       taken_cnt_reg;

   logic              issue;
   logic              taken;
   logic [PC_W-1:0]   off_sext;
   logic [PC_W-1:0]   target;

   // An issue is only accepted in RUN; the checker sees 000 otherwise so a
   // stray jump during FLUSH/BOOT/HALT has nothing to act on.
   assign issue  = (state_reg == RUN) && instr_valid;
   assign branch = issue ? branch_code : CODE_NONE;

   // Code 000 never jumps even if the checker claims it does; halt wins over
   // any branch resolved in the same cycle.
   assign taken  = issue && jump && (branch_code != CODE_NONE) && !halt_req;

   // Word offset is sign-extended to PC width and scaled to bytes; the add
   // wraps modulo 2^PC_W naturally.
   assign off_sext = PC_W'($signed(offset));
   assign target   = (branch_code == CODE_BR) ? {reg_target[PC_W-1:2], 2'b00}
                                              : pc_reg + (off_sext << 2);

   assign carry     = carry_reg;
   assign zero      = zero_reg;
   assign sign      = sign_reg;
   assign pc        = pc_reg;
   assign pc_valid  = pc_valid_reg;
   assign flush     = flush_reg;
   assign halted    = halted_reg;
   assign taken_cnt = taken_cnt_reg;

   // Sequencer FSM: state, PC, flags, counter and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= BOOT;
         pc_reg        <= RESET_PC;
         carry_reg     <= 1'b0;
         zero_reg      <= 1'b0;
         sign_reg      <= 1'b0;
         pc_valid_reg  <= 1'b0;
         flush_reg     <= 1'b0;
         halted_reg    <= 1'b0;
         taken_cnt_reg <= 16'h0000;
      end else begin
         // Flags written in the issue cycle only affect later branches.
         if (flag_we && (state_reg != HALT)) begin
            carry_reg <= alu_carry;
            zero_reg  <= alu_zero;
            sign_reg  <= alu_sign;
         end

         case (state_reg)
            BOOT: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
            end
            RUN: begin
               if (halt_req) begin
                  state_reg    <= HALT;
                  halted_reg   <= 1'b1;
                  pc_valid_reg <= 1'b0;
               end else if (taken) begin
                  state_reg <= FLUSH;
                  flush_reg <= 1'b1;
                  pc_reg    <= target;
                  if (taken_cnt_reg != 16'hFFFF)
                     taken_cnt_reg <= taken_cnt_reg + 16'd1;
               end else if (instr_valid) begin
                  pc_reg <= pc_reg + PC_W'(4);
               end
            end
            FLUSH: begin
               // The target is already in pc; the squashed slot leaves it alone.
               flush_reg <= 1'b0;
               if (halt_req) begin
                  state_reg    <= HALT;
                  halted_reg   <= 1'b1;
                  pc_valid_reg <= 1'b0;
               end else begin
                  state_reg <= RUN;
               end
            end
            default: begin
               // HALT: only reset leaves this state.
               state_reg <= HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed testbench for branch_sequencer. The driver applies one vector per
// cycle just after the rising edge and queues the values expected mid-cycle;
// the monitor pops and compares on every falling edge.
module tb_branch_sequencer;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic [2:0]  branch_code;
   logic [25:0] offset;
   logic [31:0] reg_target;
   logic        flag_we;
   logic        alu_carry;
   logic        alu_zero;
   logic        alu_sign;
   logic        halt_req;
   logic        jump;
   logic [2:0]  branch;
   logic        carry;
   logic        zero;
   logic        sign;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush;
   logic        halted;
   logic [15:0] taken_cnt;

   typedef struct {
      int          id;
      logic [2:0]  br;
      logic [31:0] pc;
      logic        pcv;
      logic        fl;
      logic        h;
      logic [15:0] cnt;
      logic [2:0]  flags;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   vec_id = 0;
   bit   preload = 1'b0;

   branch_sequencer #(
      .PC_W     (32),
      .OFF_W    (26),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .branch_code (branch_code),
      .offset      (offset),
      .reg_target  (reg_target),
      .flag_we     (flag_we),
      .alu_carry   (alu_carry),
      .alu_zero    (alu_zero),
      .alu_sign    (alu_sign),
      .halt_req    (halt_req),
      .jump        (jump),
      .branch      (branch),
      .carry       (carry),
      .zero        (zero),
      .sign        (sign),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .flush       (flush),
      .halted      (halted),
      .taken_cnt   (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
      end
   endtask

   // One vector: inputs for this cycle plus the values expected mid-cycle.
   task automatic cyc(input logic r, input logic iv, input logic [2:0] code,
                      input logic [25:0] off, input logic [31:0] rt,
                      input logic fwe, input logic [2:0] aflags,
                      input logic hreq, input logic jmp,
                      input logic [2:0] e_br, input logic [31:0] e_pc,
                      input logic e_pcv, input logic e_fl, input logic e_h,
                      input logic [15:0] e_cnt, input logic [2:0] e_flags);
      exp_t e;
      @(posedge clk);
      #1;
      if (preload) begin
         dut.taken_cnt_reg = 16'hFFFE;
         preload = 1'b0;
      end
      rst         = r;
      instr_valid = iv;
      branch_code = code;
      offset      = off;
      reg_target  = rt;
      flag_we     = fwe;
      {alu_carry, alu_zero, alu_sign} = aflags;
      halt_req    = hreq;
      jump        = jmp;
      e.id = vec_id; e.br = e_br; e.pc = e_pc; e.pcv = e_pcv; e.fl = e_fl;
      e.h = e_h; e.cnt = e_cnt; e.flags = e_flags;
      exp_q.push_back(e);
      vec_id++;
   endtask

   // Monitor: compare every queued expectation mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("vec%0d br=%0d pc=%h pcv=%0d flush=%0d halted=%0d cnt=%h czs=%b%b%b",
                     e.id, branch, pc, pc_valid, flush, halted, taken_cnt, carry, zero, sign);
            chk(e.id, "branch",    32'(branch),    32'(e.br));
            chk(e.id, "pc",        pc,             e.pc);
            chk(e.id, "pc_valid",  32'(pc_valid),  32'(e.pcv));
            chk(e.id, "flush",     32'(flush),     32'(e.fl));
            chk(e.id, "halted",    32'(halted),    32'(e.h));
            chk(e.id, "taken_cnt", 32'(taken_cnt), 32'(e.cnt));
            chk(e.id, "flags",     32'({carry, zero, sign}), 32'(e.flags));
         end
      end
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; branch_code = 3'b000; offset = '0;
      reg_target = '0; flag_we = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
      alu_sign = 1'b0; halt_req = 1'b0; jump = 1'b0;

      //  r  iv code  offset         reg_target    fwe czs    hr jp | br pc            pcv fl h cnt       czs
      cyc(1, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // reset
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // BOOT
      cyc(0, 1, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      1, 0, 0, 16'h0000, 3'b000);
      cyc(0, 1, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h104,      1, 0, 0, 16'h0000, 3'b000);
      cyc(0, 1, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h108,      1, 0, 0, 16'h0000, 3'b000);
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h10C,      1, 0, 0, 16'h0000, 3'b000); // idle
      cyc(0, 1, 3'd2, 26'd0,         32'h200,      0, 3'b000, 0, 1,  3'd2, 32'h10C,      1, 0, 0, 16'h0000, 3'b000); // br 0x200
      cyc(0, 1, 3'd1, 26'd0,         32'h0,        0, 3'b000, 0, 1,  3'd0, 32'h200,      1, 1, 0, 16'h0001, 3'b000); // FLUSH ignores issue
      cyc(0, 1, 3'd1, 26'h3FFFFFE,   32'h0,        0, 3'b000, 0, 1,  3'd1, 32'h200,      1, 0, 0, 16'h0001, 3'b000); // b -2
      cyc(0, 1, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h1F8,      1, 1, 0, 16'h0002, 3'b000); // FLUSH
      cyc(0, 1, 3'd4, 26'd5,         32'h0,        1, 3'b010, 0, 0,  3'd4, 32'h1F8,      1, 0, 0, 16'h0002, 3'b000); // bz, old zero=0
      cyc(0, 1, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 1,  3'd0, 32'h1FC,      1, 0, 0, 16'h0002, 3'b010); // code0 jump ignored
      cyc(0, 1, 3'd2, 26'd0,         32'h1237,     0, 3'b000, 0, 1,  3'd2, 32'h200,      1, 0, 0, 16'h0002, 3'b010); // br 0x1237
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        1, 3'b101, 0, 0,  3'd0, 32'h1234,     1, 1, 0, 16'h0003, 3'b010); // flag_we in FLUSH
      cyc(0, 1, 3'd2, 26'd0,         32'hFFFFFFFF, 0, 3'b000, 0, 1,  3'd2, 32'h1234,     1, 0, 0, 16'h0003, 3'b101);
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'hFFFFFFFC, 1, 1, 0, 16'h0004, 3'b101);
      cyc(0, 1, 3'd1, 26'd1,         32'h0,        0, 3'b000, 0, 1,  3'd1, 32'hFFFFFFFC, 1, 0, 0, 16'h0004, 3'b101); // wrap
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h0,        1, 1, 0, 16'h0005, 3'b101);
      cyc(0, 1, 3'd5, 26'd7,         32'h0,        0, 3'b000, 0, 0,  3'd5, 32'h0,        1, 0, 0, 16'h0005, 3'b101); // bnz not taken
      cyc(0, 1, 3'd1, 26'd8,         32'h0,        0, 3'b000, 1, 1,  3'd1, 32'h4,        1, 0, 0, 16'h0005, 3'b101); // halt + taken
      cyc(0, 1, 3'd1, 26'd8,         32'h0,        1, 3'b010, 0, 1,  3'd0, 32'h4,        0, 0, 1, 16'h0005, 3'b101); // HALT, flag_we
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h4,        0, 0, 1, 16'h0005, 3'b101); // flags kept
      cyc(1, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // reset from HALT
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // BOOT
      preload = 1'b1;
      cyc(0, 1, 3'd2, 26'd0,         32'h300,      0, 3'b000, 0, 1,  3'd2, 32'h100,      1, 0, 0, 16'hFFFE, 3'b000);
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h300,      1, 1, 0, 16'hFFFF, 3'b000);
      cyc(0, 1, 3'd1, 26'd4,         32'h0,        0, 3'b000, 0, 1,  3'd1, 32'h300,      1, 0, 0, 16'hFFFF, 3'b000);
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h310,      1, 1, 0, 16'hFFFF, 3'b000); // saturated
      cyc(0, 1, 3'd2, 26'd0,         32'h400,      0, 3'b000, 0, 1,  3'd2, 32'h310,      1, 0, 0, 16'hFFFF, 3'b000);
      cyc(1, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // reset mid-FLUSH
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      0, 0, 0, 16'h0000, 3'b000); // BOOT
      cyc(0, 0, 3'd0, 26'd0,         32'h0,        0, 3'b000, 0, 0,  3'd0, 32'h100,      1, 0, 0, 16'h0000, 3'b000); // RUN

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
